// File: rtl/usb_mem_pkg.sv
// usb_mem_pkg
//   Shared definitions for the USB packet-memory bus arbiter:
//   arbiter state encoding, requester ids and the bus word-address width.
package usb_mem_pkg;

    // Arbiter states. LOCK0/LOCK1 are only reachable when the
    // USB_MEM_ARB_LOCK_EN build option is defined.
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // Requester ids (also the value carried by the response tag).
    localparam logic ID_CPU = 1'b0;
    localparam logic ID_DMA = 1'b1;

    // Bus-side word address width (byte address bits [9:2]).
    localparam int MEM_AW = 8;

endpackage

// File: rtl/usb_mem_arb_lock.sv
// usb_mem_arb_lock
//   Locked-burst state machine for usb_mem_arbiter. Tracks which requester
//   (if any) owns the bus and how many beats it has taken, and tells the
//   grant logic when the owner must give way to a waiting peer.
//   Only built when USB_MEM_ARB_LOCK_EN is defined.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   avalid[1:0]     request valid per requester (bit N = mN)
//   alock[1:0]      lock request per requester
//   grant[1:0]      one-hot accept issued by the top this cycle
//   lock_active     1 while in LOCK0/LOCK1
//   lock_id         owner id while lock_active
//   force_release   owner hit MAX_BURST and the other requester is waiting
//   state           current FSM state (debug visibility)
module usb_mem_arb_lock
    import usb_mem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] avalid,
    input  logic [1:0] alock,
    input  logic [1:0] grant,
    output logic       lock_active,
    output logic       lock_id,
    output logic       force_release,
    output arb_state_e state
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

    arb_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    assign state         = state_q;
    assign lock_active   = (state_q != ARB);
    assign lock_id       = (state_q == LOCK1) ? ID_DMA : ID_CPU;
    assign force_release = lock_active && (cnt_q == MAX_CNT) && avalid[~lock_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB: begin
                if (grant[0] && alock[0]) begin
                    state_d = LOCK0;
                    cnt_d   = 8'd1;
                end else if (grant[1] && alock[1]) begin
                    state_d = LOCK1;
                    cnt_d   = 8'd1;
                end
            end
            LOCK0, LOCK1: begin
                // Any cycle the owner does not take a locked beat ends the
                // lock: it dropped avalid, released alock, or was forced out.
                if (grant[lock_id] && alock[lock_id]) begin
                    // Saturate so an uncontended owner can stream forever.
                    cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 8'd1;
                end else begin
                    state_d = ARB;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = ARB;
                cnt_d   = 8'd0;
            end
        endcase
    end

endmodule

// File: rtl/usb_mem_arbiter.sv
// usb_mem_arbiter
//   Shares the 32-bit bus port of the USB packet memory between the CPU bus
//   slave (m0) and the endpoint DMA engine (m1). One access per cycle,
//   round-robin between simultaneous requesters, optional locked bursts.
//   Each accepted access is tagged so the memory's fixed one-cycle response
//   is steered back to the requester that issued it.
//
// Build option
//   USB_MEM_ARB_LOCK_EN  enables LOCK0/LOCK1, the burst counter and the
//                        MAX_BURST forced release. Undefined: alock ignored,
//                        pure round-robin.
//
// Handshake: a requester raises mN_avalid with stable fields and holds them
//   until mN_aready is seen high in the same cycle; that cycle is the
//   transfer. The memory never stalls, so s_avalid is exactly the OR of the
//   two aready outputs, and s_bvalid arrives exactly one cycle later.
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   mN_avalid/awe/aaddr/adata/astrb   request from requester N
//   mN_alock                          hold grant after this beat
//   mN_aready                         request N accepted this cycle
//   mN_bvalid, mN_bdata               response to requester N
//   s_avalid/awe/aaddr/adata/astrb    request to the memory
//   s_bvalid, s_bdata                 memory response
//   dbg_state                         arbiter state for debug visibility
module usb_mem_arbiter
    import usb_mem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_avalid,
    output logic              m0_aready,
    input  logic              m0_awe,
    input  logic [MEM_AW-1:0] m0_aaddr,
    input  logic [31:0]       m0_adata,
    input  logic [3:0]        m0_astrb,
    input  logic              m0_alock,
    output logic              m0_bvalid,
    output logic [31:0]       m0_bdata,
    input  logic              m1_avalid,
    output logic              m1_aready,
    input  logic              m1_awe,
    input  logic [MEM_AW-1:0] m1_aaddr,
    input  logic [31:0]       m1_adata,
    input  logic [3:0]        m1_astrb,
    input  logic              m1_alock,
    output logic              m1_bvalid,
    output logic [31:0]       m1_bdata,
    output logic              s_avalid,
    output logic              s_awe,
    output logic [MEM_AW-1:0] s_aaddr,
    output logic [31:0]       s_adata,
    output logic [3:0]        s_astrb,
    input  logic              s_bvalid,
    input  logic [31:0]       s_bdata,
    output arb_state_e        dbg_state
);

    logic [1:0] avalid;
    logic [1:0] grant;
    logic       rr_q;        // id of the last granted requester
    logic       tag_q;       // id owning the response due this cycle
    logic       inflight_q;  // a response is due this cycle
    logic       lock_active;
    logic       lock_id;
    logic       force_release;

    assign avalid = {m1_avalid, m0_avalid};

`ifdef USB_MEM_ARB_LOCK_EN
    usb_mem_arb_lock #(
        .MAX_BURST (MAX_BURST)
    ) u_lock (
        .clk           (clk),
        .rst_n         (rst_n),
        .avalid        (avalid),
        .alock         ({m1_alock, m0_alock}),
        .grant         (grant),
        .lock_active   (lock_active),
        .lock_id       (lock_id),
        .force_release (force_release),
        .state         (dbg_state)
    );
`else
    logic unused_lock;
    assign unused_lock   = ^{m0_alock, m1_alock, MAX_BURST[0]};
    assign lock_active   = 1'b0;
    assign lock_id       = ID_CPU;
    assign force_release = 1'b0;
    assign dbg_state     = ARB;
`endif

    // Grant: the lock owner wins unless it is idle or being forced out, in
    // which case the other requester may take this same cycle. Otherwise
    // a tie goes to the requester that was not granted last.
    always_comb begin
        grant = 2'b00;
        if (lock_active) begin
            if (avalid[lock_id] && !force_release) begin
                grant[lock_id] = 1'b1;
            end else if (avalid[~lock_id]) begin
                grant[~lock_id] = 1'b1;
            end
        end else if (&avalid) begin
            grant[~rr_q] = 1'b1;
        end else begin
            grant = avalid;
        end
    end

    assign m0_aready = grant[0];
    assign m1_aready = grant[1];
    assign s_avalid  = |grant;

    always_comb begin
        s_awe   = 1'b0;
        s_aaddr = '0;
        s_adata = 32'd0;
        s_astrb = 4'd0;
        if (grant[0]) begin
            s_awe   = m0_awe;
            s_aaddr = m0_aaddr;
            s_adata = m0_adata;
            s_astrb = m0_astrb;
        end else if (grant[1]) begin
            s_awe   = m1_awe;
            s_aaddr = m1_aaddr;
            s_adata = m1_adata;
            s_astrb = m1_astrb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= ID_DMA;
            tag_q      <= ID_CPU;
            inflight_q <= 1'b0;
        end else begin
            if (s_avalid) begin
                rr_q <= grant[1];
            end
            tag_q      <= grant[1];
            inflight_q <= s_avalid;
        end
    end

    // A response with nothing in flight (e.g. one issued before a reset)
    // is dropped here.
    assign m0_bvalid = s_bvalid && inflight_q && (tag_q == ID_CPU);
    assign m1_bvalid = s_bvalid && inflight_q && (tag_q == ID_DMA);
    assign m0_bdata  = s_bdata;
    assign m1_bdata  = s_bdata;

endmodule
